// File: rtl/multdiv_pkg.sv
// Shared constants and the state encoding for the mul/div sequencer.
package multdiv_pkg;

  localparam logic [4:0] OP_RTYPE    = 5'b00000;
  localparam logic [4:0] ALU_MUL     = 5'b00110;
  localparam logic [4:0] ALU_DIV     = 5'b00111;
  localparam logic [4:0] RSTATUS_IDX = 5'd30;
  localparam int         MUL_EXC     = 4;
  localparam int         DIV_EXC     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_wait_counter.sv
// Saturating WAIT-cycle counter with synchronous clear and a compare-to-limit flag.
module md_wait_counter #(
  parameter int WIDTH = 6,
  parameter int LIMIT = 39
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != '1)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign at_limit = (count_reg == WIDTH'(LIMIT));

endmodule

// File: rtl/multdiv_sequencer.sv
// Stalls the core while the shared iterative multiplier/divider runs mul/div, then writes back.
// Optional watchdog abort of a hung WAIT is enabled by defining MULTDIV_WATCHDOG_EN.
module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int LATENCY_MAX  = 40,
  parameter int RSTATUS_REG  = RSTATUS_IDX,
  parameter int MUL_EXC_CODE = MUL_EXC,
  parameter int DIV_EXC_CODE = DIV_EXC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        timeout
);

  localparam int CNT_W = $clog2(LATENCY_MAX + 1);

  md_state_t   state_reg, state_next;
  logic        detect;
  logic        at_limit;
  logic        watchdog_fire;
  logic [4:0]  rd_reg;
  logic        is_div_reg;
  logic [31:0] result_reg;
  logic        exc_reg;
  logic        timeout_reg;

  assign detect = issue_valid && (opcode == OP_RTYPE) &&
                  ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));

  md_wait_counter #(
    .WIDTH (CNT_W),
    .LIMIT (LATENCY_MAX - 1)
  ) u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_reg == START),
    .enable   (state_reg == WAIT),
    .at_limit (at_limit)
  );

`ifdef MULTDIV_WATCHDOG_EN
  // A ready arriving on the limit cycle still wins over the abort.
  assign watchdog_fire = (state_reg == WAIT) && at_limit && !md_ready;
`else
  logic unused_at_limit;
  assign unused_at_limit = at_limit;
  assign watchdog_fire   = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (detect) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (md_ready || watchdog_fire) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_reg      <= '0;
      is_div_reg  <= 1'b0;
      result_reg  <= '0;
      exc_reg     <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && detect) begin
        rd_reg     <= rd;
        is_div_reg <= (alu_op == ALU_DIV);
      end
      if ((state_reg == WAIT) && md_ready) begin
        result_reg  <= md_result;
        exc_reg     <= md_exception;
        timeout_reg <= 1'b0;
      end else if (watchdog_fire) begin
        exc_reg     <= 1'b1;
        timeout_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    stall     = 1'b0;
    wb_en     = 1'b0;
    wb_reg    = '0;
    wb_data   = '0;
    timeout   = 1'b0;
    case (state_reg)
      IDLE:  stall = detect;
      START: begin
        stall     = 1'b1;
        ctrl_mult = !is_div_reg;
        ctrl_div  = is_div_reg;
      end
      WAIT:  stall = 1'b1;
      WRITE: begin
        if (exc_reg) begin
          wb_reg  = 5'(RSTATUS_REG);
          wb_data = is_div_reg ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
        end else begin
          wb_reg  = rd_reg;
          wb_data = result_reg;
        end
        wb_en   = (wb_reg != '0);
        timeout = timeout_reg;
      end
      default: ;
    endcase
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: directed plus random mul/div traffic.
module tb_multdiv_sequencer;

`ifdef MULTDIV_WATCHDOG_EN
  localparam int LAT = 8;
  localparam bit WD  = 1'b1;
`else
  localparam int LAT = 40;
  localparam bit WD  = 1'b0;
`endif
  localparam int RST_CYC = WD ? 5 : 10;

  logic        clock, reset, issue_valid, md_exception, md_ready;
  logic [4:0]  opcode, alu_op, rd;
  logic [31:0] md_result;
  logic        ctrl_mult, ctrl_div, stall, wb_en, busy, timeout;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  typedef struct {
    logic        en;
    logic [4:0]  r;
    logic [31:0] d;
    logic        to;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  multdiv_sequencer #(.LATENCY_MAX(LAT)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .opcode(opcode),
    .alu_op(alu_op), .rd(rd), .md_result(md_result), .md_exception(md_exception),
    .md_ready(md_ready), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall(stall),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy), .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every WRITE cycle (busy with stall released) consumes one expected writeback.
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      if (busy && !stall) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got wb_reg=%0d wb_data=%h expected no writeback", wb_reg, wb_data);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk1("wb_en", wb_en, e.en);
          chk32("wb_reg", 32'(wb_reg), 32'(e.r));
          chk32("wb_data", wb_data, e.d);
          chk1("timeout", timeout, e.to);
          $display("write: wb_en=%0d wb_reg=%0d wb_data=%h timeout=%0d", wb_en, wb_reg, wb_data, timeout);
        end
      end else begin
        chk1("wb_en_outside_write", wb_en, 1'b0);
        chk32("wb_data_outside_write", wb_data, 32'h0);
        chk1("timeout_outside_write", timeout, 1'b0);
      end
    end
  end

  // Issue one mul/div whose unit answers in cycle k (k >= 2); checks stall/busy/start pulses each cycle.
  task automatic run_op(input bit is_div, input logic [4:0] r, input int k,
                        input logic [31:0] res, input bit exc);
    bit  abort;
    int  k_eff;
    wb_t e;
    abort = WD && (k > LAT + 1);
    k_eff = abort ? LAT + 1 : k;
    e.to  = abort;
    if (exc || abort) begin
      e.r = 5'd30;
      e.d = is_div ? 32'd5 : 32'd4;
    end else begin
      e.r = r;
      e.d = res;
    end
    e.en = (e.r != 5'd0);
    exp_q.push_back(e);
    $display("issue: %s rd=%0d ready_cycle=%0d result=%h exc=%0d", is_div ? "div" : "mul", r, k, res, exc);
    issue_valid = 1'b1; opcode = 5'b00000; alu_op = is_div ? 5'b00111 : 5'b00110; rd = r;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'h0;
    for (int c = 0; c <= k_eff + 1; c++) begin
      if (c > 0) begin
        // Detect-looking noise while busy and in WRITE must be ignored.
        issue_valid  = (c == k_eff + 1) ? 1'b1 : 1'($urandom_range(0, 1));
        opcode       = 5'b00000;
        alu_op       = 5'b00110;
        rd           = 5'($urandom);
        md_ready     = (c == k) || ((c == 1) && ($urandom_range(0, 1) == 1));
        md_result    = (c == k) ? res : $urandom;
        md_exception = (c == k) ? exc : 1'($urandom_range(0, 1));
      end
      #1;
      chk1("stall", stall, c <= k_eff);
      chk1("busy", busy, c >= 1);
      chk1("ctrl_mult", ctrl_mult, (c == 1) && !is_div);
      chk1("ctrl_div", ctrl_div, (c == 1) && is_div);
      @(negedge clock);
    end
    issue_valid = 1'b0; md_ready = 1'b0;
  endtask

  // Non-mul/div instructions: must not stall, start the unit, or leave IDLE.
  task automatic idle_cycle(input logic iv, input logic [4:0] op, input logic [4:0] alu);
    issue_valid = iv; opcode = op; alu_op = alu; rd = 5'($urandom);
    md_ready = 1'($urandom_range(0, 1)); md_result = $urandom;
    #1;
    chk1("idle_stall", stall, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_ctrl_mult", ctrl_mult, 1'b0);
    chk1("idle_ctrl_div", ctrl_div, 1'b0);
    @(negedge clock);
    issue_valid = 1'b0; md_ready = 1'b0;
  endtask

  task automatic random_idle();
    logic [4:0] a;
    case ($urandom_range(0, 2))
      0: idle_cycle(1'b0, 5'b00000, 5'b00110);
      1: begin
        do a = 5'($urandom); while (a == 5'b00110 || a == 5'b00111);
        idle_cycle(1'b1, 5'b00000, a);
      end
      default: begin
        do a = 5'($urandom); while (a == 5'b00000);
        idle_cycle(1'b1, a, 5'b00111);
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within time limit");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1; issue_valid = 1'b0; opcode = 5'b0; alu_op = 5'b0; rd = 5'b0;
    md_result = 32'h0; md_exception = 1'b0; md_ready = 1'b0;
    @(negedge clock);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_ctrl_mult", ctrl_mult, 1'b0);
    chk1("rst_wb_en", wb_en, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    issue_valid = 1'b1; alu_op = 5'b00110;
    #1;
    chk1("rst_stall_follows_detect", stall, 1'b1);
    chk1("rst_busy_held", busy, 1'b0);
    @(negedge clock);
    reset = 1'b0; issue_valid = 1'b0;

    // Directed cases
    run_op(1'b0, 5'd5, 34, 32'h0000_0042, 1'b0);
    run_op(1'b1, 5'd7, 5, 32'h1234_5678, 1'b1);
    run_op(1'b0, 5'd12, 3, 32'hdead_beef, 1'b1);
    run_op(1'b0, 5'd0, 4, 32'h0000_0099, 1'b0);
    idle_cycle(1'b1, 5'b00000, 5'b00000);
    idle_cycle(1'b1, 5'b00101, 5'b00110);
    run_op(1'b1, 5'd9, LAT + 1, 32'h0bad_f00d, 1'b0);
    run_op(1'b0, 5'd3, 102, 32'h0000_0777, 1'b0);
    run_op(1'b1, 5'd21, LAT + 2, 32'h0000_0101, 1'b0);

    // Reset in WAIT, then a late ready: must return to IDLE with no writeback or new start.
    $display("issue: mul rd=9 with reset in cycle %0d", RST_CYC);
    issue_valid = 1'b1; opcode = 5'b00000; alu_op = 5'b00110; rd = 5'd9;
    for (int c = 0; c < RST_CYC; c++) begin
      @(negedge clock);
      issue_valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_stall", stall, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    md_ready = 1'b1; md_result = 32'h5555_aaaa;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk1("postrst_busy", busy, 1'b0);
      chk1("postrst_ctrl_mult", ctrl_mult, 1'b0);
      chk1("postrst_ctrl_div", ctrl_div, 1'b0);
      @(negedge clock);
      md_ready = 1'b0;
    end

    // Random traffic, including back-to-back issues (zero idle gap).
    for (int n = 0; n < 40; n++) begin
      int gap;
      run_op(1'($urandom_range(0, 1)), 5'($urandom), $urandom_range(2, LAT + 4),
             $urandom, ($urandom_range(0, 3) == 0));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) random_idle();
    end

    repeat (3) @(negedge clock);
    #3;
    chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
